// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
//   state_t  : controller states (IDLE / ADD / DONE)
//   NIBBLE_W : width of one digit processed per cycle
package nibble_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_adder_pkg

// File: rtl/CarryRippleAdder.sv
// Purely combinational 4-bit ripple-carry adder.
//   A, B : 4-bit addends
//   Cin  : carry in
//   Sum  : 4-bit sum
//   Cout : carry out of bit 3
module CarryRippleAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  // Full-adder chain, bit 0 first
  always_comb begin
    logic c;
    c   = Cin;
    Sum = '0;
    for (int i = 0; i < 4; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule : CarryRippleAdder

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: accepts a/b/cin with a valid/ready handshake, adds one
// 4-bit digit per cycle through a single ripple adder, then presents
// sum/cout/ovf with a valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum                 : (a+b+cin) mod 2^W
//   cout                : carry out of the MSB
//   ovf                 : signed overflow (carry into MSB xor carry out)
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;
  logic                msb_cin;

  // Current digit of the latched operands
  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  CarryRippleAdder u_cra (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  // Carry into the top bit of the digit, recovered from its sum bit
  assign msb_cin = nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = nib_cout;
          ovf_d   = msb_cin ^ nib_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): directed corner
// cases, backpressure, mid-transaction reset, then randomized traffic scored
// against an arithmetic reference.
module tb_nibble_serial_adder;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic         out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    s    = full[W-1:0];
    o    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {o, full[W], s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One transaction with fixed expectations and an optional DONE stall
  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    step;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(NIB));
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_cout"}, 32'(cout), 32'(ecout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      step;
      chk({tag, "_stall_sum"}, 32'({ovf, cout, sum}), 32'({eovf, ecout, esum}));
      chk({tag, "_stall_rdy"}, 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk({tag, "_post_hs"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    int acc, done, cyc;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({in_ready, out_valid, cout, ovf, sum}), 32'({4'b1000, 16'h0000}));
    step;
    step;
    #2 rst_n = 1'b1;
    chk("rst_release", 32'({in_ready, out_valid}), 32'b10);

    // Corner cases; first accept lands on the first edge after reset release
    directed("zero",  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    directed("sovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    directed("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 5);
    directed("b2b",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    // Reset two cycles into ADD discards the partial result
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'({in_ready, out_valid, cout, ovf, sum}), 32'({4'b1000, 16'h0000}));
    step;
    #2 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (out_valid) cyc++;
    end
    chk("midrst_no_valid", 32'(cyc), 32'd0);
    chk("midrst_idle", 32'({in_ready, sum}), 32'({1'b1, 16'h0000}));
    directed("fresh", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

    // Random traffic with independent in_valid / out_ready gaps
    acc = 0; done = 0; cyc = 0;
    while ((acc < 1000 || q.size() > 0) && cyc < 40000) begin
      in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        chk("rand_no_dup", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rand_result", 32'({ovf, cout, sum}), 32'(e));
          done++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_res(a, b, cin));
        acc++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_accepted", 32'(acc), 32'd1000);
    chk("rand_completed", 32'(done), 32'd1000);
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit digits per operand; W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set a/b/cin is valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry into nibble 0.
REQ-009 out_valid  output  1  sum/cout/ovf valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  W  registered result (a+b+cin) mod 2^W.
REQ-012 cout  output  1  carry out of the MSB nibble.
REQ-013 ovf  output  1  signed overflow: carry into bit W-1 XOR cout.

Function
REQ-014 FSM states: IDLE, ADD, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready, latch a, b, cin; clear idx to 0; go to ADD.
REQ-016 IDLE with in_valid low: hold state; sum/cout/ovf keep their last values.
REQ-017 ADD: each cycle, feed nibble idx of latched a/b plus the carry register into one 4-bit ripple adder; write its 4-bit sum into sum[4*idx+3:4*idx]; load its carry-out into the carry register.
REQ-018 ADD: idx increments by 1 per cycle; on the cycle with idx==NIBBLES-1, load cout and ovf, then go to DONE.
REQ-019 Latency: accept at edge k gives out_valid high after edge k+NIBBLES (4 cycles for the default).
REQ-020 DONE: sum/cout/ovf are stable while out_valid is high; on out_valid&&out_ready, go to IDLE.
REQ-021 Back-to-back: in_ready rises the cycle after the result handshake; no operand is accepted while in ADD or DONE.
REQ-022 Carry register initialised from the latched cin at accept; the carry never wraps between transactions.
REQ-023 idx width = clog2(NIBBLES), minimum 1; idx never exceeds NIBBLES-1.
REQ-024 Inputs a/b/cin may change freely after accept without affecting the result.

Reset
REQ-025 rst_n low: state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
REQ-026 Reset asserted mid-ADD or in DONE aborts the transaction; the partial result is discarded and never presented.
REQ-027 After rst_n deasserts, the first accept is possible on the first rising edge.

Structure
REQ-028 Package nibble_adder_pkg holds the state enum (IDLE/ADD/DONE) and the constant NIBBLE_W=4.
REQ-029 Exactly one instance of the existing 4-bit CarryRippleAdder (ports A, B, Cin, Sum, Cout) performs all arithmetic; the block contains no other adder.
REQ-030 The block keeps its own datapath registers; the instantiated adder stays purely combinational.

Verification (NIBBLES=4)
REQ-031 a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all nibbles).
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-034 Backpressure: out_ready held low for 5 cycles in DONE -> sum/cout/ovf unchanged, in_ready=0, a concurrent in_valid is not accepted; accept occurs the cycle after out_ready rises.
REQ-035 Reset pulse 2 cycles into ADD with a=0x1234, b=0x1111 -> all outputs 0, out_valid never rises, in_ready=1; a fresh a=0x1234, b=0x1111 then gives sum=0x2345.
REQ-036 Random 1000 transactions with random in_valid/out_ready gaps -> every result equals the reference (a+b+cin) and no transaction is lost or duplicated.
